// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with fill level, almost-full/empty thresholds,
// sticky error flags and synchronous flush. Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr_p0;
  logic [ADDR_W:0]   rptr_p0;
  logic [DATA_W-1:0] rdata_p0;
  logic              rd_ok;
  logic              wr_ok;

  assign full         = (wptr_p0[ADDR_W] != rptr_p0[ADDR_W]) &&
                        (wptr_p0[ADDR_W-1:0] == rptr_p0[ADDR_W-1:0]);
  assign empty        = (wptr_p0 == rptr_p0);
  assign count        = wptr_p0 - rptr_p0;
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // A write at full is only accepted when a read frees a slot in the same cycle.
  assign rd_ok = read_en & ~empty;
  assign wr_ok = write_en & (~full | rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok && !flush && !rst)
      mem[wptr_p0[ADDR_W-1:0]] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_p0   <= '0;
      rptr_p0   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wptr_p0 <= wptr_p0 + 1'b1;
      if (rd_ok)
        rptr_p0 <= rptr_p0 + 1'b1;
      if (write_en && !wr_ok)
        overflow <= 1'b1;
      if (read_en && !rd_ok)
        underflow <= 1'b1;
    end
  end

  // Last popped word: the registered output in standard mode, the idle value in FWFT mode.
  always_ff @(posedge clk) begin
    if (rst)
      rdata_p0 <= '0;
    else if (rd_ok && !flush)
      rdata_p0 <= mem[rptr_p0[ADDR_W-1:0]];
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign read_data = empty ? rdata_p0 : mem[rptr_p0[ADDR_W-1:0]];
`else
  assign read_data = rdata_p0;
`endif

endmodule
